// File: rtl/traffic_phase_controller_pkg.sv
// Shared types and constants for the traffic phase controller.
// Latency: n/a (types, constants and one pure helper only).
// Backpressure: n/a.
// Holds the 3-bit phase encoding and the one-hot {R,Y,G} lamp codes.
// Optional feature macro: TRAFFIC_FLASH_MODE_EN adds the ST_FLASH phase.
package traffic_phase_controller_pkg;

   typedef enum logic [2:0] {
      ST_NS_GREEN  = 3'd0,
      ST_NS_YELLOW = 3'd1,
      ST_RED_A     = 3'd2,
      ST_EW_GREEN  = 3'd3,
      ST_EW_YELLOW = 3'd4,
      ST_RED_B     = 3'd5
`ifdef TRAFFIC_FLASH_MODE_EN
      ,
      ST_FLASH     = 3'd6
`endif
   } phase_t;

   localparam logic [2:0] LAMP_RED = 3'b100;
   localparam logic [2:0] LAMP_YEL = 3'b010;
   localparam logic [2:0] LAMP_GRN = 3'b001;
   localparam logic [2:0] LAMP_OFF = 3'b000;

   // Flashing lamp: yellow in the "on" half period, dark in the "off" half.
   function automatic logic [2:0] flash_lamp(input logic on);
      return on ? LAMP_YEL : LAMP_OFF;
   endfunction

endpackage

// File: rtl/traffic_phase_controller_phase_decode.sv
// Combinational phase decode: phase -> NS/EW lamps, walk and timer reload count.
// Latency: zero cycles (pure combinational).
// Backpressure: none; outputs follow the phase every cycle.
// Ports: state (current phase), flash_on (flash half-period, macro build only),
//        ns_lamp/ew_lamp (one-hot {R,Y,G}), walk, count (timer reload value).
// Optional feature macro: TRAFFIC_FLASH_MODE_EN.
module traffic_phase_controller_phase_decode
   import traffic_phase_controller_pkg::*;
#(
   parameter int BIT_WIDTH  = 4,
   parameter int NS_GREEN   = 9,
   parameter int EW_GREEN   = 6,
   parameter int YELLOW     = 2,
   parameter int ALL_RED    = 1,
   parameter int FLASH_HALF = 3
) (
   input  phase_t               state,
`ifdef TRAFFIC_FLASH_MODE_EN
   input  logic                 flash_on,
`endif
   output logic [2:0]           ns_lamp,
   output logic [2:0]           ew_lamp,
   output logic                 walk,
   output logic [BIT_WIDTH-1:0] count
);

   // Counts are cut down to the timer width; callers keep them below 2^BIT_WIDTH.
   localparam logic [BIT_WIDTH-1:0] CNT_NSG = BIT_WIDTH'(NS_GREEN);
   localparam logic [BIT_WIDTH-1:0] CNT_EWG = BIT_WIDTH'(EW_GREEN);
   localparam logic [BIT_WIDTH-1:0] CNT_YEL = BIT_WIDTH'(YELLOW);
   localparam logic [BIT_WIDTH-1:0] CNT_RED = BIT_WIDTH'(ALL_RED);
`ifdef TRAFFIC_FLASH_MODE_EN
   localparam logic [BIT_WIDTH-1:0] CNT_FLS = BIT_WIDTH'(FLASH_HALF);
`else
   localparam int flash_half_unused = FLASH_HALF;
`endif

   always_comb begin
      ns_lamp = LAMP_RED;
      ew_lamp = LAMP_RED;
      walk    = 1'b0;
      count   = CNT_RED;
      case (state)
         ST_NS_GREEN: begin
            ns_lamp = LAMP_GRN;
            count   = CNT_NSG;
         end
         ST_NS_YELLOW: begin
            ns_lamp = LAMP_YEL;
            count   = CNT_YEL;
         end
         ST_EW_GREEN: begin
            ew_lamp = LAMP_GRN;
            walk    = 1'b1;
            count   = CNT_EWG;
         end
         ST_EW_YELLOW: begin
            ew_lamp = LAMP_YEL;
            count   = CNT_YEL;
         end
`ifdef TRAFFIC_FLASH_MODE_EN
         ST_FLASH: begin
            ns_lamp = flash_lamp(flash_on);
            ew_lamp = flash_lamp(flash_on);
            count   = CNT_FLS;
         end
`endif
         default: ;  // both all-red phases use the defaults
      endcase
   end

endmodule

// File: rtl/traffic_phase_controller.sv
// Two-road phase sequencer driving a saturating countdown timer and the lamps.
// Latency: outputs are decoded from registered phase/entry; lamps change the cycle after the advancing edge.
// Backpressure: none; phases advance only on timer expiry, NS green holds until EW demand.
// Ports: clk, reset (async active-low), ewCar (level), pedReq (pulse), flash,
//        timerZero (timer isZero), timerLoad/timerDown/timerLoadIn (timer controls),
//        nsLight/ewLight (one-hot {R,Y,G}), walk (EW pedestrian).
// Optional feature macro: TRAFFIC_FLASH_MODE_EN (flash input ignored without it).
module traffic_phase_controller
   import traffic_phase_controller_pkg::*;
#(
   parameter int BIT_WIDTH  = 4,
   parameter int NS_GREEN   = 9,
   parameter int EW_GREEN   = 6,
   parameter int YELLOW     = 2,
   parameter int ALL_RED    = 1,
   parameter int FLASH_HALF = 3
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 ewCar,
   input  logic                 pedReq,
   input  logic                 flash,
   input  logic                 timerZero,
   output logic                 timerLoad,
   output logic                 timerDown,
   output logic [BIT_WIDTH-1:0] timerLoadIn,
   output logic [2:0]           nsLight,
   output logic [2:0]           ewLight,
   output logic                 walk
);

   phase_t state, state_nxt;
   logic   entry, entry_nxt;
   logic   demand, demand_nxt;
   logic   expired;
   logic   reload;

`ifdef TRAFFIC_FLASH_MODE_EN
   logic   flash_on, flash_on_nxt;
`else
   logic   flash_unused;
   assign flash_unused = flash;
`endif

   // On the entry cycle the timer still holds the previous phase's count,
   // so its zero flag is only trusted from the second cycle on.
   assign expired = !entry && timerZero;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= ST_RED_B;
         entry  <= 1'b1;
         demand <= 1'b0;
`ifdef TRAFFIC_FLASH_MODE_EN
         flash_on <= 1'b0;
`endif
      end else begin
         state  <= state_nxt;
         entry  <= entry_nxt;
         demand <= demand_nxt;
`ifdef TRAFFIC_FLASH_MODE_EN
         flash_on <= flash_on_nxt;
`endif
      end
   end

   always_comb begin
      state_nxt  = state;
      reload     = 1'b0;
      demand_nxt = demand;
      case (state)
         ST_NS_GREEN:  if (expired && demand) state_nxt = ST_NS_YELLOW;
         ST_NS_YELLOW: if (expired) state_nxt = ST_RED_A;
         ST_RED_A:     if (expired) state_nxt = ST_EW_GREEN;
         ST_EW_GREEN:  if (expired) state_nxt = ST_EW_YELLOW;
         ST_EW_YELLOW: if (expired) state_nxt = ST_RED_B;
         ST_RED_B:     if (expired) state_nxt = ST_NS_GREEN;
`ifdef TRAFFIC_FLASH_MODE_EN
         ST_FLASH: begin
            if (!flash)       state_nxt = ST_RED_B;
            else if (expired) reload    = 1'b1;  // next half period
         end
`endif
         default:      state_nxt = ST_RED_B;
      endcase

`ifdef TRAFFIC_FLASH_MODE_EN
      if (flash && state != ST_FLASH) state_nxt = ST_FLASH;
`endif

      entry_nxt = (state_nxt != state) || reload;

      // Requests are accepted outside EW green; the clear on entering EW green
      // wins over a simultaneous request (a held ewCar re-arms it later).
      if ((ewCar || pedReq) && state != ST_EW_GREEN) demand_nxt = 1'b1;
      if (state_nxt == ST_EW_GREEN && state != ST_EW_GREEN) demand_nxt = 1'b0;

`ifdef TRAFFIC_FLASH_MODE_EN
      if (state == ST_FLASH) demand_nxt = demand;
      flash_on_nxt = flash_on;
      if (state_nxt == ST_FLASH && state != ST_FLASH) flash_on_nxt = 1'b1;
      else if (reload)                                 flash_on_nxt = !flash_on;
`endif
   end

   traffic_phase_controller_phase_decode #(
      .BIT_WIDTH (BIT_WIDTH),
      .NS_GREEN  (NS_GREEN),
      .EW_GREEN  (EW_GREEN),
      .YELLOW    (YELLOW),
      .ALL_RED   (ALL_RED),
      .FLASH_HALF(FLASH_HALF)
   ) u_decode (
      .state   (state),
`ifdef TRAFFIC_FLASH_MODE_EN
      .flash_on(flash_on),
`endif
      .ns_lamp (nsLight),
      .ew_lamp (ewLight),
      .walk    (walk),
      .count   (timerLoadIn)
   );

   assign timerLoad = entry;
   assign timerDown = !entry;

endmodule

// File: tb/tb_traffic_phase_controller.sv
// Bench for traffic_phase_controller with an attached saturating countdown timer.
// Latency: n/a.
// Backpressure: n/a.
module tb_traffic_phase_controller;

   localparam int BW  = 4;
   localparam int NSG = 9;
   localparam int EWG = 6;
   localparam int YEL = 2;
   localparam int ARD = 1;
   localparam int FLH = 3;

   localparam logic [2:0] R = 3'b100, Y = 3'b010, G = 3'b001;

   // Phases in road order; dwell of each phase is its count + 2 cycles.
   localparam int P_NSG = 0, P_NSY = 1, P_RA = 2, P_EWG = 3, P_EWY = 4, P_RB = 5;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          ewCar = 1'b0, pedReq = 1'b0, flash = 1'b0;
   logic          timerZero, timerLoad, timerDown, walk;
   logic [BW-1:0] timerLoadIn;
   logic [2:0]    nsLight, ewLight;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   traffic_phase_controller #(
      .BIT_WIDTH(BW), .NS_GREEN(NSG), .EW_GREEN(EWG),
      .YELLOW(YEL), .ALL_RED(ARD), .FLASH_HALF(FLH)
   ) dut (
      .clk(clk), .reset(reset), .ewCar(ewCar), .pedReq(pedReq), .flash(flash),
      .timerZero(timerZero), .timerLoad(timerLoad), .timerDown(timerDown),
      .timerLoadIn(timerLoadIn), .nsLight(nsLight), .ewLight(ewLight), .walk(walk)
   );

   // Downstream saturating countdown timer.
   logic [BW-1:0] tcnt = '0;
   always @(posedge clk) begin
      if (timerLoad)                  tcnt <= timerLoadIn;
      else if (timerDown && tcnt != 0) tcnt <= tcnt - 1'b1;
   end
   assign timerZero = (tcnt == 0);

   // Reference model: phase, cycles spent in it, latched EW demand.
   int m_phase, m_age;
   bit m_dem;

   function automatic int phase_count(input int p);
      case (p)
         P_NSG:        return NSG;
         P_NSY, P_EWY: return YEL;
         P_EWG:        return EWG;
         default:      return ARD;
      endcase
   endfunction

   function automatic logic [2:0] ns_exp(input int p);
      return (p == P_NSG) ? G : (p == P_NSY) ? Y : R;
   endfunction

   function automatic logic [2:0] ew_exp(input int p);
      return (p == P_EWG) ? G : (p == P_EWY) ? Y : R;
   endfunction

   task automatic model_reset();
      m_phase = P_RB;
      m_age   = 0;
      m_dem   = 1'b0;
   endtask

   task automatic model_step(input bit ew, input bit ped);
      bit adv;
      adv = (m_age >= phase_count(m_phase) + 1) && (m_phase != P_NSG || m_dem);
      if (m_phase != P_EWG && (ew || ped)) m_dem = 1'b1;
      if (adv) begin
         m_phase = (m_phase + 1) % 6;
         m_age   = 0;
         if (m_phase == P_EWG) m_dem = 1'b0;
      end else if (m_age < 1000) begin
         m_age++;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   logic [2:0] obs_ns, obs_ew;
   logic       obs_walk, obs_load;

   // Called just after a rising edge: drive inputs, compare mid-cycle, advance model.
   task automatic step(input bit ew, input bit ped);
      logic [12:0] exp;
      ewCar  = ew;
      pedReq = ped;
      #3;
      exp = {ns_exp(m_phase), ew_exp(m_phase), (m_phase == P_EWG), (m_age == 0),
             (m_age != 0), BW'(phase_count(m_phase))};
      chk("cycle", {nsLight, ewLight, walk, timerLoad, timerDown, timerLoadIn}, exp);
      obs_ns = nsLight; obs_ew = ewLight; obs_walk = walk; obs_load = timerLoad;
      @(posedge clk);
      if (reset) model_step(ew, ped);
      else       model_reset();
      #1;
   endtask

   // Asynchronous reset assertion mid-cycle, held across one edge.
   task automatic do_reset();
      reset = 1'b0; ewCar = 1'b0; pedReq = 1'b0;
      #1;
      chk("rst_lamps", {nsLight, ewLight}, {R, R});
      chk("rst_walk", walk, 0);
      chk("rst_timer", {timerLoad, timerDown, timerLoadIn}, {1'b1, 1'b0, BW'(ARD)});
      model_reset();
      @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   task automatic wait_ns_green(input string tag);
      int n = 0;
      bit seen = 0;
      for (int k = 0; k < 20 && !seen; k++) begin
         step(0, 0);
         if (obs_ns == G) seen = 1;
         else n++;
      end
      chk({tag, "_seen"}, seen, 1);
      chk({tag, "_red_cycles"}, n, ARD + 2);
   endtask

   logic [6:0] pats[$];
   int         run_len[$];
   logic [6:0] run_pat[$];

   initial begin
      int loads, nongreen, exp_len[6];
      logic [6:0] exp_pat[7];
      bit seen, ped_ew_done, ew_lvl;

      // Power-up reset, then NS green must persist without demand.
      #2;
      do_reset();
      wait_ns_green("release1");
      loads = obs_load; nongreen = 0;
      for (int i = 0; i < 120; i++) begin
         step(0, 0);
         loads += obs_load;
         if (obs_ns != G) nongreen++;
      end
      chk("idle_loads", loads, 1);
      chk("idle_nongreen", nongreen, 0);

      // Car pulse starts a cycle; reset lands in the middle of EW green.
      step(1, 0);
      seen = 0;
      for (int k = 0; k < 40 && !seen; k++) begin
         step(0, 0);
         if (obs_walk) seen = 1;
      end
      chk("walk_seen", seen, 1);
      step(0, 0);
      step(0, 0);
      do_reset();
      wait_ns_green("release2");

      // Pedestrian pulse during the NS green count; second pulse during EW green.
      pats.push_back({obs_ns, obs_ew, obs_walk});
      ped_ew_done = 0;
      for (int i = 1; i <= 40; i++) begin
         bit ped;
         ped = (i == 3);
         if (obs_walk && !ped_ew_done) begin
            ped = 1;
            ped_ew_done = 1;
         end
         step(0, ped);
         pats.push_back({obs_ns, obs_ew, obs_walk});
      end
      foreach (pats[i]) begin
         if (run_pat.size() == 0 || run_pat[run_pat.size()-1] != pats[i]) begin
            run_pat.push_back(pats[i]);
            run_len.push_back(1);
         end else begin
            run_len[run_len.size()-1]++;
         end
      end
      exp_len = '{NSG + 2, YEL + 2, ARD + 2, EWG + 2, YEL + 2, ARD + 2};
      exp_pat = '{{G, R, 1'b0}, {Y, R, 1'b0}, {R, R, 1'b0}, {R, G, 1'b1},
                  {R, Y, 1'b0}, {R, R, 1'b0}, {G, R, 1'b0}};
      chk("run_count", (run_pat.size() >= 7), 1);
      for (int i = 0; i < 7; i++) begin
         if (i < run_pat.size()) begin
            chk($sformatf("run%0d_pat", i), run_pat[i], exp_pat[i]);
            if (i < 6) chk($sformatf("run%0d_len", i), run_len[i], exp_len[i]);
         end
      end

      // Pedestrian press during EW green must not bring EW back.
      nongreen = 0;
      for (int i = 0; i < 40; i++) begin
         step(0, 0);
         if (obs_ns != G) nongreen++;
      end
      chk("ped_in_ewg_ignored", nongreen, 0);

      // Random demand with occasional asynchronous resets.
      ew_lvl = 0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(399) == 0) begin
            do_reset();
            ew_lvl = 0;
         end else begin
            if ($urandom_range(24) == 0) ew_lvl = !ew_lvl;
            step(ew_lvl, ($urandom_range(39) == 0));
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/traffic_phase_controller.md
Name: traffic_phase_controller

Overview:
- Phase-sequencing FSM for a two-road intersection (NS main road, EW side road).
- Sits directly upstream of the saturation countdown timer: it drives the timer's `down`, `load` and `loadIn` inputs, and consumes the timer's `isZero` to advance phases.
- Drives the NS/EW lamp outputs and the EW pedestrian walk signal.
- NS rests in green; EW is served only on vehicle or pedestrian demand.

Parameters:
- BIT_WIDTH, 4, timer count width; must match the downstream timer.
- NS_GREEN, 9, minimum NS green count loaded into the timer.
- EW_GREEN, 6, EW green count.
- YELLOW, 2, yellow count (both roads).
- ALL_RED, 1, all-red clearance count.
- FLASH_HALF, 3, half-period count for flash mode (used only with the macro).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- ewCar  input  1  EW vehicle sensor, level.
- pedReq  input  1  pedestrian button; a one-cycle pulse is sufficient.
- flash  input  1  flash-mode request (ignored without the macro).
- timerZero  input  1  `isZero` from the timer.
- timerLoad  output  1  timer `load`.
- timerDown  output  1  timer `down`.
- timerLoadIn  output  BIT_WIDTH  timer `loadIn`.
- nsLight  output  3  one-hot {R,Y,G}.
- ewLight  output  3  one-hot {R,Y,G}.
- walk  output  1  EW pedestrian walk.

Behaviour:
- States: NS_GREEN, NS_YELLOW, RED_A, EW_GREEN, EW_YELLOW, RED_B (+FLASH with the macro).
- State and `entry` flag are registers. `entry` is 1 in the first cycle of every state.
- Reset (reset=0, asynchronous):
  - state=RED_B, entry=1, demand latch=0.
  - Outputs while in reset: nsLight=ewLight=3'b100, walk=0, timerLoad=1, timerDown=0, timerLoadIn=ALL_RED.
- Timer protocol:
  - Entry cycle: timerLoad=1, timerDown=0, timerLoadIn=the state's count.
  - All other cycles: timerLoad=0, timerDown=1.
- Advance rule:
  - The state advances at the clock edge where entry=0 and timerZero=1.
  - timerZero is ignored in the entry cycle, because the timer's count is still stale then.
  - Dwell for a count N = N+2 cycles: one load cycle, N decrement cycles, one zero cycle. A count of 0 gives 2 cycles.
- Transitions:
  - NS_GREEN -> NS_YELLOW only when the timer has expired AND demand=1. Otherwise NS_GREEN holds with timerDown=1 (timer saturates at 0), entry stays 0, and it transitions on the first cycle demand=1.
  - NS_YELLOW -> RED_A -> EW_GREEN -> EW_YELLOW -> RED_B -> NS_GREEN, each on expiry.
- Demand latch:
  - Set by ewCar|pedReq in any state except EW_GREEN.
  - Cleared at the edge entering EW_GREEN.
  - Set-and-clear in the same cycle: clear wins. A request present in that cycle is lost, except ewCar, which is a level and re-sets the latch later.
  - pedReq during EW_GREEN is ignored.
- Lamps:
  - NS is G/Y in NS_GREEN/NS_YELLOW, R otherwise.
  - EW is G/Y in EW_GREEN/EW_YELLOW, R otherwise.
  - Never both non-red.
- walk=1 throughout EW_GREEN only.
- timerLoadIn is zero-extended/truncated to BIT_WIDTH. Counts must be < 2^BIT_WIDTH.
- Outputs are combinational from registered state/entry; no input-to-output combinational path except none. Lamp changes appear the cycle after the advancing edge.

Optional Feature:
- Macro: TRAFFIC_FLASH_MODE_EN.
- With the macro:
  - flash=1 sampled at any edge forces state=FLASH, entry=1 (from any state, including mid-count).
  - In FLASH: nsLight=ewLight toggle between 3'b010 and 3'b000, each phase FLASH_HALF+2 cycles via the timer (reload on each toggle). walk=0. Demand latch holds.
  - flash=0 -> RED_B with entry=1.
- Without the macro: flash is unused, the FLASH state does not exist, and lamps never show 3'b000.

Decomposition:
- Shared package:
  - State encoding constants (3-bit).
  - Lamp constants: LAMP_RED=3'b100, LAMP_YEL=3'b010, LAMP_GRN=3'b001, LAMP_OFF=3'b000.
- One natural sub-module: phase_decode, a combinational state -> {nsLight, ewLight, walk, count} mapping.
- The FSM, entry flag and demand latch stay in the top.

Test Plan:
- Reset low mid-EW_GREEN, release -> same cycle both lamps red, walk=0, timerLoad=1, loadIn=1; NS_GREEN is reached 3 cycles after release (RED_B dwell 1+2).
- Timer model attached, ewCar=0 and pedReq=0 forever -> NS green persists 100+ cycles; timerLoad pulses only once.
- pedReq 1-cycle pulse during NS_GREEN count -> NS_GREEN 11 cycles total, NS_YELLOW 4, RED_A 3, EW_GREEN 8 with walk=1, EW_YELLOW 4, RED_B 3, back to NS_GREEN.
- pedReq pulsed during EW_GREEN, ewCar=0 -> demand stays 0; NS_GREEN holds after the cycle completes.
- Stale-zero check: timer model returns timerZero=1 on the entry cycle of NS_YELLOW -> no advance; the state lasts exactly 4 cycles.
- With TRAFFIC_FLASH_MODE_EN, flash=1 mid-NS_GREEN -> next cycle FLASH, lamps 010 for 5 cycles then 000 for 5 cycles; flash=0 -> RED_B then NS_GREEN.
